control_cmd_fillarea_loader: RTL and testbench

- Upstream stage of control_subcmd_fillarea, directly feeding it.
- Collects the fill-area command payload from the command byte stream: x1, y1, width, height and color.
- Validates and clips the geometry, then drives the subcommand's enable/ack handshake until the fill completes.
- Sits between the top-level command decoder and control_subcmd_fillarea.

---
 rtl/control_pkg.sv | 32 +++
 rtl/control_field_shifter.sv | 25 ++
 rtl/control_cmd_fillarea_loader.sv | 165 ++++++++++++++++
 tb/tb_control_cmd_fillarea_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared state encoding and field-width derivations for the fill-area command path
package control_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_X1,
    ST_RX_Y1,
    ST_RX_W,
    ST_RX_H,
    ST_RX_COLOR,
    ST_CHECK,
    ST_RUN,
    ST_DRAIN,
    ST_ACK,
    ST_DONE
  } loader_state_t;

  function automatic int bytes_for(input int bits);
    return (bits + 7) / 8;
  endfunction

  localparam int DEF_PIXEL_WIDTH     = 64;
  localparam int DEF_PIXEL_HEIGHT    = 32;
  localparam int DEF_BYTES_PER_PIXEL = 2;

  // Decoder, loader and subcommand all size column/row fields from these.
  localparam int NCB = $clog2(DEF_PIXEL_WIDTH);
  localparam int NRB = $clog2(DEF_PIXEL_HEIGHT);
  localparam int CB  = bytes_for(NCB);
  localparam int RB  = bytes_for(NRB);

endpackage

// File: rtl/control_field_shifter.sv
// rtl/control_field_shifter.sv - big-endian byte-to-field assembler with a parallel load for post-processing
module control_field_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic [7:0]       data_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value
);

  // Older bytes move toward the MSB; anything past WIDTH falls off the top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (shift) begin
      value <= WIDTH'({value, data_in});
    end
  end

endmodule

// File: rtl/control_cmd_fillarea_loader.sv
// rtl/control_cmd_fillarea_loader.sv - collects fill-area payload, clips geometry and sequences the fill subcommand
module control_cmd_fillarea_loader
  import control_pkg::*;
#(
  parameter int PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT    = DEF_PIXEL_HEIGHT,
  parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_start,
  input  logic [7:0]                         data_in,
  input  logic                               data_valid,
  output logic                               busy,
  output logic [$clog2(PIXEL_WIDTH)-1:0]     x1,
  output logic [$clog2(PIXEL_HEIGHT)-1:0]    y1,
  output logic [$clog2(PIXEL_WIDTH)-1:0]     width,
  output logic [$clog2(PIXEL_HEIGHT)-1:0]    height,
  output logic [BYTES_PER_PIXEL*8-1:0]       color,
  output logic                               sub_enable,
  output logic                               sub_ack,
  input  logic                               sub_done,
  output logic                               cmd_done
);

  localparam int COL_BITS  = $clog2(PIXEL_WIDTH);
  localparam int ROW_BITS  = $clog2(PIXEL_HEIGHT);
  localparam int COL_BYTES = bytes_for(COL_BITS);
  localparam int ROW_BYTES = bytes_for(ROW_BITS);
  localparam int CNTW      = 8;
  localparam logic [COL_BITS:0] COL_LIMIT = (COL_BITS + 1)'(PIXEL_WIDTH);
  localparam logic [ROW_BITS:0] ROW_LIMIT = (ROW_BITS + 1)'(PIXEL_HEIGHT);

  loader_state_t       state;
  loader_state_t       rx_next;
  logic [CNTW-1:0]     cnt;
  int                  field_bytes;
  logic                field_last;
  logic                in_rx;

  logic [COL_BITS:0]   col_avail, col_clip;
  logic [ROW_BITS:0]   row_avail, row_clip;
  logic                zero_size;

  always_comb begin
    field_bytes = 1;
    rx_next     = ST_CHECK;
    in_rx       = 1'b1;
    case (state)
      ST_RX_X1:    begin field_bytes = COL_BYTES;       rx_next = ST_RX_Y1;    end
      ST_RX_Y1:    begin field_bytes = ROW_BYTES;       rx_next = ST_RX_W;     end
      ST_RX_W:     begin field_bytes = COL_BYTES;       rx_next = ST_RX_H;     end
      ST_RX_H:     begin field_bytes = ROW_BYTES;       rx_next = ST_RX_COLOR; end
      ST_RX_COLOR: begin field_bytes = BYTES_PER_PIXEL; rx_next = ST_CHECK;    end
      default:     in_rx = 1'b0;
    endcase
  end

  assign field_last = (cnt == CNTW'(field_bytes - 1));

  // Clipping is done one bit wider so PIXEL_WIDTH - x1 cannot wrap.
  always_comb begin
    col_avail = ({1'b0, x1} >= COL_LIMIT) ? '0 : COL_LIMIT - {1'b0, x1};
    row_avail = ({1'b0, y1} >= ROW_LIMIT) ? '0 : ROW_LIMIT - {1'b0, y1};
    col_clip  = ({1'b0, width}  < col_avail) ? {1'b0, width}  : col_avail;
    row_clip  = ({1'b0, height} < row_avail) ? {1'b0, height} : row_avail;
    zero_size = (col_clip == '0) || (row_clip == '0);
  end

  logic sh_x1, sh_y1, sh_w, sh_h, sh_color, clip_load;

  assign sh_x1     = data_valid && (state == ST_RX_X1);
  assign sh_y1     = data_valid && (state == ST_RX_Y1);
  assign sh_w      = data_valid && (state == ST_RX_W);
  assign sh_h      = data_valid && (state == ST_RX_H);
  assign sh_color  = data_valid && (state == ST_RX_COLOR);
  assign clip_load = (state == ST_CHECK);

  control_field_shifter #(.WIDTH(COL_BITS)) u_x1 (
    .clk(clk), .reset(reset), .shift(sh_x1), .data_in(data_in),
    .load(1'b0), .load_value('0), .value(x1)
  );

  control_field_shifter #(.WIDTH(ROW_BITS)) u_y1 (
    .clk(clk), .reset(reset), .shift(sh_y1), .data_in(data_in),
    .load(1'b0), .load_value('0), .value(y1)
  );

  control_field_shifter #(.WIDTH(COL_BITS)) u_width (
    .clk(clk), .reset(reset), .shift(sh_w), .data_in(data_in),
    .load(clip_load), .load_value(col_clip[COL_BITS-1:0]), .value(width)
  );

  control_field_shifter #(.WIDTH(ROW_BITS)) u_height (
    .clk(clk), .reset(reset), .shift(sh_h), .data_in(data_in),
    .load(clip_load), .load_value(row_clip[ROW_BITS-1:0]), .value(height)
  );

  control_field_shifter #(.WIDTH(BYTES_PER_PIXEL * 8)) u_color (
    .clk(clk), .reset(reset), .shift(sh_color), .data_in(data_in),
    .load(1'b0), .load_value('0), .value(color)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      sub_enable <= 1'b0;
      sub_ack    <= 1'b0;
      cmd_done   <= 1'b0;
    end else begin
      sub_ack  <= 1'b0;
      cmd_done <= 1'b0;
      if (in_rx) begin
        if (data_valid) begin
          if (field_last) begin
            cnt   <= '0;
            state <= rx_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_start) begin
              state <= ST_RX_X1;
              busy  <= 1'b1;
              cnt   <= '0;
            end
          end
          ST_CHECK: begin
            if (zero_size) begin
              state    <= ST_DONE;
              cmd_done <= 1'b1;
            end else begin
              state      <= ST_RUN;
              sub_enable <= 1'b1;
            end
          end
          ST_RUN: begin
            if (sub_done) state <= ST_DRAIN;
          end
          // One extra enabled cycle lets the subcommand finish its last write.
          ST_DRAIN: begin
            state      <= ST_ACK;
            sub_enable <= 1'b0;
            sub_ack    <= 1'b1;
          end
          ST_ACK: begin
            state    <= ST_DONE;
            cmd_done <= 1'b1;
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_cmd_fillarea_loader.sv
// tb/tb_control_cmd_fillarea_loader.sv - directed self-checking bench for the fill-area loader
module tb_control_cmd_fillarea_loader;

  logic        clk = 1'b0;
  logic        reset, cmd_start, data_valid, sub_done;
  logic [7:0]  data_in;
  logic        busy, sub_enable, sub_ack, cmd_done;
  logic [5:0]  x1, width;
  logic [4:0]  y1, height;
  logic [15:0] color;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_cmd_fillarea_loader dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .data_in(data_in),
    .data_valid(data_valid), .busy(busy), .x1(x1), .y1(y1), .width(width),
    .height(height), .color(color), .sub_enable(sub_enable), .sub_ack(sub_ack),
    .sub_done(sub_done), .cmd_done(cmd_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [47:0] p, input int max_gap);
    for (int i = 0; i < 6; i++) begin
      send_byte(p[47-8*i -: 8]);
      if (i < 5) repeat (i % (max_gap + 1)) tick();
    end
  endtask

  task automatic finish_run;
    sub_done = 1'b1;
    tick();
    sub_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
    total++; if (sub_enable !== 1'b0) begin bad++; $display("FAIL reset_sub_enable got=%0h want=0", sub_enable); end
    total++; if (sub_ack !== 1'b0) begin bad++; $display("FAIL reset_sub_ack got=%0h want=0", sub_ack); end
    total++; if (cmd_done !== 1'b0) begin bad++; $display("FAIL reset_cmd_done got=%0h want=0", cmd_done); end
    total++; if ({x1, y1, width, height, color} !== 38'd0) begin bad++; $display("FAIL reset_fields got=%0h want=0", {x1, y1, width, height, color}); end
  endtask

  task automatic test_normal_fill;
    bit en_ok;
    start_cmd();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL normal_busy got=%0h want=1", busy); end
    send_payload(48'h04_02_03_02_AB_CD, 3);
    total++; if (sub_enable !== 1'b0) begin bad++; $display("FAIL normal_en_check got=%0h want=0", sub_enable); end
    tick();
    total++; if (sub_enable !== 1'b1) begin bad++; $display("FAIL normal_en_n2 got=%0h want=1", sub_enable); end
    total++; if ({x1, y1, width, height} !== {6'd4, 5'd2, 6'd3, 5'd2}) begin bad++; $display("FAIL normal_geom got=%0d,%0d,%0d,%0d want=4,2,3,2", x1, y1, width, height); end
    total++; if (color !== 16'hABCD) begin bad++; $display("FAIL normal_color got=%0h want=abcd", color); end
    en_ok = 1'b1;
    repeat (11) begin
      tick();
      if (sub_enable !== 1'b1 || sub_ack !== 1'b0) en_ok = 1'b0;
    end
    total++; if (en_ok !== 1'b1) begin bad++; $display("FAIL normal_run_hold got=%0h want=1", en_ok); end
    sub_done = 1'b1;
    tick();
    sub_done = 1'b0;
    total++; if ({sub_enable, sub_ack} !== 2'b10) begin bad++; $display("FAIL normal_drain got=%b want=10", {sub_enable, sub_ack}); end
    tick();
    total++; if ({sub_enable, sub_ack, cmd_done} !== 3'b010) begin bad++; $display("FAIL normal_ack got=%b want=010", {sub_enable, sub_ack, cmd_done}); end
    tick();
    total++; if ({sub_ack, cmd_done, busy} !== 3'b011) begin bad++; $display("FAIL normal_done got=%b want=011", {sub_ack, cmd_done, busy}); end
    tick();
    total++; if ({cmd_done, busy} !== 2'b00) begin bad++; $display("FAIL normal_idle got=%b want=00", {cmd_done, busy}); end
    total++; if (width !== 6'd3) begin bad++; $display("FAIL normal_retain got=%0d want=3", width); end
  endtask

  task automatic test_zero_size;
    start_cmd();
    send_payload(48'h05_05_00_04_FF_FF, 0);
    total++; if ({sub_enable, cmd_done} !== 2'b00) begin bad++; $display("FAIL zero_check got=%b want=00", {sub_enable, cmd_done}); end
    tick();
    total++; if ({sub_enable, cmd_done, busy} !== 3'b011) begin bad++; $display("FAIL zero_done got=%b want=011", {sub_enable, cmd_done, busy}); end
    total++; if ({width, height} !== {6'd0, 5'd4}) begin bad++; $display("FAIL zero_size_vals got=%0d,%0d want=0,4", width, height); end
    tick();
    total++; if ({sub_enable, cmd_done, busy} !== 3'b000) begin bad++; $display("FAIL zero_idle got=%b want=000", {sub_enable, cmd_done, busy}); end
  endtask

  task automatic test_clipping;
    start_cmd();
    send_payload(48'h3C_1E_0A_05_12_34, 1);
    tick();
    total++; if (sub_enable !== 1'b1) begin bad++; $display("FAIL clip_en got=%0h want=1", sub_enable); end
    total++; if ({x1, y1, width, height} !== {6'd60, 5'd30, 6'd4, 5'd2}) begin bad++; $display("FAIL clip_geom got=%0d,%0d,%0d,%0d want=60,30,4,2", x1, y1, width, height); end
    total++; if (color !== 16'h1234) begin bad++; $display("FAIL clip_color got=%0h want=1234", color); end
    finish_run();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clip_end_busy got=%0h want=0", busy); end
  endtask

  task automatic test_busy_rules;
    start_cmd();
    send_payload(48'h01_01_02_01_55_AA, 2);
    tick();
    cmd_start  = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'hFF;
    tick();
    cmd_start  = 1'b0;
    data_valid = 1'b0;
    total++; if ({busy, sub_enable} !== 2'b11) begin bad++; $display("FAIL busy_run got=%b want=11", {busy, sub_enable}); end
    total++; if ({x1, width, color} !== {6'd1, 6'd2, 16'h55AA}) begin bad++; $display("FAIL busy_fields got=%0h want=%0h", {x1, width, color}, {6'd1, 6'd2, 16'h55AA}); end
    sub_done = 1'b1;
    tick();
    sub_done = 1'b0;
    tick();
    tick();
    total++; if ({cmd_done, busy} !== 2'b11) begin bad++; $display("FAIL busy_done got=%b want=11", {cmd_done, busy}); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_release got=%0h want=0", busy); end
  endtask

  task automatic test_back_to_back;
    cmd_start  = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'h07;
    tick();
    cmd_start  = 1'b0;
    data_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%0h want=1", busy); end
    send_payload(48'hC2_E3_01_01_00_01, 0);
    tick();
    total++; if ({x1, y1, width, height} !== {6'd2, 5'd3, 6'd1, 5'd1}) begin bad++; $display("FAIL b2b_geom got=%0d,%0d,%0d,%0d want=2,3,1,1", x1, y1, width, height); end
    total++; if ({sub_enable, color} !== {1'b1, 16'h0001}) begin bad++; $display("FAIL b2b_color got=%0h want=10001", {sub_enable, color}); end
    finish_run();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0h want=0", busy); end
  endtask

  task automatic test_handshake;
    start_cmd();
    send_payload(48'h00_00_01_01_12_34, 0);
    tick();
    sub_done = 1'b1;
    tick();
    total++; if ({sub_enable, sub_ack} !== 2'b10) begin bad++; $display("FAIL hs_drain got=%b want=10", {sub_enable, sub_ack}); end
    tick();
    total++; if ({sub_enable, sub_ack, cmd_done} !== 3'b010) begin bad++; $display("FAIL hs_ack got=%b want=010", {sub_enable, sub_ack, cmd_done}); end
    tick();
    total++; if ({sub_enable, sub_ack, cmd_done} !== 3'b001) begin bad++; $display("FAIL hs_done got=%b want=001", {sub_enable, sub_ack, cmd_done}); end
    sub_done = 1'b0;
    tick();
    total++; if ({busy, sub_enable} !== 2'b00) begin bad++; $display("FAIL hs_idle got=%b want=00", {busy, sub_enable}); end
  endtask

  task automatic test_reset_mid;
    start_cmd();
    send_byte(8'h10);
    send_byte(8'h05);
    send_byte(8'h07);
    #2 reset = 1'b0;
    #1;
    total++; if ({busy, sub_enable, sub_ack, cmd_done} !== 4'b0000) begin bad++; $display("FAIL rst_mid_ctl got=%b want=0000", {busy, sub_enable, sub_ack, cmd_done}); end
    total++; if ({x1, y1, width, height, color} !== 38'd0) begin bad++; $display("FAIL rst_mid_fields got=%0h want=0", {x1, y1, width, height, color}); end
    tick();
    reset = 1'b1;
    tick();
    start_cmd();
    send_payload(48'h02_03_04_05_12_34, 1);
    tick();
    total++; if ({sub_enable, x1, y1, width, height} !== {1'b1, 6'd2, 5'd3, 6'd4, 5'd5}) begin bad++; $display("FAIL rst_fresh got=%0d,%0d,%0d,%0d want=2,3,4,5", x1, y1, width, height); end
    #2 reset = 1'b0;
    #1;
    total++; if ({sub_enable, busy, color} !== {1'b0, 1'b0, 16'h0}) begin bad++; $display("FAIL rst_run got=%0h want=0", {sub_enable, busy, color}); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset      = 1'b0;
    cmd_start  = 1'b0;
    data_valid = 1'b0;
    sub_done   = 1'b0;
    data_in    = 8'h00;
    repeat (2) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_normal_fill();
    test_zero_size();
    test_clipping();
    test_busy_rules();
    test_back_to_back();
    test_handshake();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
